// File: rtl/dht_read_sched.sv
// dht_read_sched: periodic read scheduler for a DHT-style humidity/temperature
// sensor reader. It launches reads, validates the frame checksum, tracks read
// timeouts and consecutive failures, and publishes the last good frame.
module dht_read_sched #(
  parameter int PERIOD_CYC  = 50000000,
  parameter int TIMEOUT_CYC = 5000000,
  parameter int MAX_FAIL    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        rd_start,
  input  logic        rd_done,
  input  logic [39:0] rd_data,
  output logic [31:0] information,
  output logic        info_valid,
  output logic [7:0]  err_cnt,
  output logic        sensor_fault,
  output logic [2:0]  state_dbg
);

  localparam int PW = $clog2(PERIOD_CYC);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]    FAIL_MAX = 4'(MAX_FAIL);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    WAIT   = 3'd2,
    CHECK  = 3'd3,
    PERIOD = 3'd4
  } state_t;

  state_t        state_r;
  logic [PW-1:0] per_cnt_r;
  logic [TW-1:0] tmo_cnt_r;
  logic [3:0]    fail_cnt_r;
  logic [39:0]   shadow_r;
  logic [31:0]   information_r;
  logic          info_valid_r;
  logic          rd_start_r;
  logic [7:0]    err_cnt_r;
  logic          sensor_fault_r;

  logic [7:0]    err_cnt_inc_s;
  logic [3:0]    fail_cnt_inc_s;
  logic          sum_ok_s;

  // Byte sum of the four payload bytes, modulo 256.
  function automatic logic [7:0] frame_checksum(input logic [39:0] frame);
    frame_checksum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
  endfunction

  // Saturating next values for the error/failure counters and checksum verdict.
  always_comb begin
    err_cnt_inc_s  = err_cnt_r;
    fail_cnt_inc_s = fail_cnt_r;
    sum_ok_s       = 1'b0;
    if (err_cnt_r == 8'd255) begin
      err_cnt_inc_s = 8'd255;
    end else begin
      err_cnt_inc_s = err_cnt_r + 8'd1;
    end
    if (fail_cnt_r >= FAIL_MAX) begin
      fail_cnt_inc_s = FAIL_MAX;
    end else begin
      fail_cnt_inc_s = fail_cnt_r + 4'd1;
    end
    if (frame_checksum(shadow_r) == shadow_r[7:0]) begin
      sum_ok_s = 1'b1;
    end else begin
      sum_ok_s = 1'b0;
    end
  end

  // Scheduler FSM with all counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      per_cnt_r      <= {PW{1'b0}};
      tmo_cnt_r      <= {TW{1'b0}};
      fail_cnt_r     <= 4'd0;
      shadow_r       <= 40'd0;
      information_r  <= 32'd0;
      info_valid_r   <= 1'b0;
      rd_start_r     <= 1'b0;
      err_cnt_r      <= 8'd0;
      sensor_fault_r <= 1'b0;
    end else begin
      rd_start_r   <= 1'b0;
      info_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (enable) begin
            rd_start_r <= 1'b1;
            state_r    <= START;
          end
        end
        START: begin
          tmo_cnt_r <= {TW{1'b0}};
          state_r   <= WAIT;
        end
        WAIT: begin
          // A response in the expiry cycle still counts as a response.
          if (rd_done) begin
            shadow_r <= rd_data;
            state_r  <= CHECK;
          end else if (tmo_cnt_r == TMO_LAST) begin
            err_cnt_r      <= err_cnt_inc_s;
            fail_cnt_r     <= fail_cnt_inc_s;
            sensor_fault_r <= (fail_cnt_inc_s == FAIL_MAX);
            per_cnt_r      <= {PW{1'b0}};
            state_r        <= PERIOD;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
          end
        end
        CHECK: begin
          if (sum_ok_s) begin
            information_r  <= shadow_r[39:8];
            info_valid_r   <= 1'b1;
            fail_cnt_r     <= 4'd0;
            sensor_fault_r <= 1'b0;
          end else begin
            err_cnt_r      <= err_cnt_inc_s;
            fail_cnt_r     <= fail_cnt_inc_s;
            sensor_fault_r <= (fail_cnt_inc_s == FAIL_MAX);
          end
          per_cnt_r <= {PW{1'b0}};
          state_r   <= PERIOD;
        end
        PERIOD: begin
          if (!enable) begin
            state_r <= IDLE;
          end else if (per_cnt_r == PER_LAST) begin
            rd_start_r <= 1'b1;
            state_r    <= START;
          end else begin
            per_cnt_r <= per_cnt_r + PW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign rd_start     = rd_start_r;
  assign information  = information_r;
  assign info_valid   = info_valid_r;
  assign err_cnt      = err_cnt_r;
  assign sensor_fault = sensor_fault_r;
  assign state_dbg    = state_r;

endmodule

// File: tb/tb_dht_read_sched.sv
// tb_dht_read_sched: randomized self-checking bench for dht_read_sched with a
// transaction-level reference model (expected outputs and start spacing are
// derived per read from delay, response and frame checksum).
module tb_dht_read_sched;
  localparam int P  = 100;
  localparam int T  = 20;
  localparam int MF = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        rd_start;
  logic        rd_done;
  logic [39:0] rd_data;
  logic [31:0] information;
  logic        info_valid;
  logic [7:0]  err_cnt;
  logic        sensor_fault;
  logic [2:0]  state_dbg;

  dht_read_sched #(.PERIOD_CYC(P), .TIMEOUT_CYC(T), .MAX_FAIL(MF)) dut (
    .clk(clk), .rst(rst), .enable(enable), .rd_start(rd_start),
    .rd_done(rd_done), .rd_data(rd_data), .information(information),
    .info_valid(info_valid), .err_cnt(err_cnt), .sensor_fault(sensor_fault),
    .state_dbg(state_dbg)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          last_start = 0;
  int          exp_gap = 0;
  bit          gap_known = 1'b0;
  int          exp_err  = 0;
  int          exp_fail = 0;
  bit          exp_fault = 1'b0;
  logic [31:0] exp_info = 32'd0;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int byte_sum(input logic [39:0] frame);
    int s;
    s = 0;
    for (int b = 1; b < 5; b++) s += int'((frame >> (8 * b)) & 40'hFF);
    return s % 256;
  endfunction

  function automatic logic [39:0] mk_frame(input bit good);
    logic [31:0] d;
    logic [7:0]  cs;
    d  = $urandom;
    cs = 8'(byte_sum({d, 8'd0}));
    if (!good) cs = cs ^ 8'($urandom_range(1, 255));
    return {d, cs};
  endfunction

  // Advance to the next falling edge; inputs default to idle/garbage.
  task automatic step();
    @(negedge clk);
    cyc++;
    rd_done = 1'b0;
    rd_data = {8'($urandom), 32'($urandom)};
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (rd_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("rd_start_seen", 40'(rd_start), 40'd1);
    end else begin
      if (gap_known) check("start_gap", 40'(cyc - last_start), 40'(exp_gap));
      last_start = cyc;
      gap_known  = 1'b1;
    end
  endtask

  // One read: respond k cycles after rd_start (late pulses land in PERIOD).
  task automatic txn(input int k, input logic [39:0] frame, input bit respond, input int drop_at);
    bit ok;
    bit succ;
    bit pass;
    int last;
    wait_start(ok);
    if (!ok) return;
    succ = respond && (k <= T);
    pass = succ && (byte_sum(frame) == int'(frame[7:0]));
    last = succ ? k + 2 : ((respond && k > T + 1) ? k : T + 1);
    for (int j = 1; j <= last; j++) begin
      step();
      if (j == drop_at) enable = 1'b0;
      if (j == 1) begin
        check("rd_start_width", 40'(rd_start), 40'd0);
        check("state_wait", 40'(state_dbg), 40'd2);
      end
      if (!succ && j == T) check("wait_len", 40'(state_dbg), 40'd2);
      if ((succ && j == k + 2) || (!succ && j == T + 1)) begin
        if (pass) begin
          exp_info  = frame[39:8];
          exp_fail  = 0;
          exp_fault = 1'b0;
        end else begin
          if (exp_err < 255) exp_err++;
          if (exp_fail < MF) exp_fail++;
          exp_fault = (exp_fail == MF);
        end
        check("info_valid", 40'(info_valid), 40'(pass));
        check("information", 40'(information), 40'(exp_info));
        check("err_cnt", 40'(err_cnt), 40'(exp_err));
        check("sensor_fault", 40'(sensor_fault), 40'(exp_fault));
        check("state_period", 40'(state_dbg), 40'd4);
        exp_gap = succ ? k + 2 + P : T + 1 + P;
      end else begin
        check("no_info_valid", 40'(info_valid), 40'd0);
      end
      if (respond && j == k) begin
        rd_done = 1'b1;
        rd_data = frame;
      end
    end
  endtask

  initial begin
    bit ok;
    rst = 1'b1; enable = 1'b0; rd_done = 1'b0; rd_data = 40'd0;
    #1;
    check("rst_state", 40'(state_dbg), 40'd0);
    check("rst_outputs", {rd_start, info_valid, sensor_fault, err_cnt, information}, 40'd0);
    repeat (3) step();
    rst = 1'b0;
    step();
    check("idle_hold", 40'(state_dbg), 40'd0);
    check("idle_no_start", 40'(rd_start), 40'd0);
    enable = 1'b1;

    // Directed: good, bad, good, three timeouts, recovery, collision.
    txn(5, 40'h3A00190558, 1'b1, 0);
    check("good_info", 40'(information), 40'h3A001905);
    txn(5, 40'h3A00190557, 1'b1, 0);
    txn(7, mk_frame(1'b1), 1'b1, 0);
    for (int i = 0; i < 3; i++) txn(0, 40'd0, 1'b0, 0);
    check("fault_after_3", 40'(sensor_fault), 40'd1);
    txn(4, mk_frame(1'b1), 1'b1, 0);
    check("fault_cleared", 40'(sensor_fault), 40'd0);
    txn(T, mk_frame(1'b1), 1'b1, 0);

    // Randomized reads.
    for (int i = 0; i < 40; i++) begin
      txn(int'($urandom_range(1, 26)), mk_frame($urandom_range(0, 3) != 0),
          $urandom_range(0, 4) != 0, 0);
    end

    // Error counter saturation.
    for (int i = 0; i < 300; i++) txn(1, mk_frame(1'b0), 1'b1, 0);
    check("err_saturated", 40'(err_cnt), 40'd255);

    // Enable dropped mid-WAIT: read completes, then idle, then restart.
    txn(6, mk_frame(1'b1), 1'b1, 3);
    for (int i = 0; i < 150; i++) begin
      step();
      check("idle_no_rd_start", 40'(rd_start), 40'd0);
    end
    check("idle_after_drop", 40'(state_dbg), 40'd0);
    enable = 1'b1;
    last_start = cyc;
    gap_known  = 1'b1;
    exp_gap    = 1;
    txn(3, mk_frame(1'b1), 1'b1, 0);

    // Reset pulsed mid-WAIT, then a late rd_done.
    wait_start(ok);
    for (int j = 1; j <= 4; j++) step();
    #2 rst = 1'b1;
    #1;
    check("async_rst_state", 40'(state_dbg), 40'd0);
    check("async_rst_outputs", {rd_start, info_valid, sensor_fault, err_cnt, information}, 40'd0);
    step();
    enable = 1'b0;
    step();
    rst = 1'b0;
    step();
    rd_done = 1'b1;
    rd_data = 40'h3A00190558;
    for (int j = 0; j < 3; j++) begin
      step();
      check("post_rst_state", 40'(state_dbg), 40'd0);
      check("post_rst_outputs", {rd_start, info_valid, sensor_fault, err_cnt, information}, 40'd0);
    end
    exp_err = 0; exp_fail = 0; exp_fault = 1'b0; exp_info = 32'd0;
    gap_known = 1'b0;
    enable = 1'b1;
    txn(9, mk_frame(1'b1), 1'b1, 0);
    txn(2, mk_frame(1'b0), 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
